// File: rtl/textmode_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : textmode_pkg
//  Description : Shared geometry, control codes and state type for the
//                text-mode console feeder.
//  Revision    : 1.0  initial release
// ============================================================================
package textmode_pkg;

    // Character array geometry
    localparam int TM_COLS = 80;
    localparam int TM_ROWS = 30;

    // Control codes interpreted by the console
    localparam logic [7:0] CC_BS = 8'h08;
    localparam logic [7:0] CC_LF = 8'h0A;
    localparam logic [7:0] CC_FF = 8'h0C;
    localparam logic [7:0] CC_CR = 8'h0D;

    // Printable range, inclusive on both ends (0x7F is drawn as a glyph)
    localparam logic [7:0] PRINT_LO = 8'h20;
    localparam logic [7:0] PRINT_HI = 8'h7F;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        CLR_LINE   = 2'd1,
        CLR_SCREEN = 2'd2
    } console_state_t;

endpackage
`default_nettype wire

// File: rtl/text_console_if.sv
`default_nettype none
// ============================================================================
//  Interface   : text_console_if
//  Description : Byte input handshake plus the character-write strobe bus
//                toward the character array.
//  Revision    : 1.0  initial release
// ============================================================================
interface text_console_if;

    logic [7:0] in_chr;
    logic       in_valid;
    logic       in_ready;

    logic [6:0] char_x;
    logic [5:0] char_y;
    logic [8:0] char_chr;
    logic       char_str;

    // Byte producer side (CPU/UART or bench)
    modport master (
        output in_chr, in_valid,
        input  in_ready, char_x, char_y, char_chr, char_str
    );

    // Console side
    modport slave (
        input  in_chr, in_valid,
        output in_ready, char_x, char_y, char_chr, char_str
    );

endinterface
`default_nettype wire

// File: rtl/text_console.sv
`default_nettype none
// ============================================================================
//  Module      : text_console
//  Description : Consumes a byte stream, tracks a cursor, interprets control
//                codes and emits single-cycle character writes. Rows are
//                cleared on entry instead of scrolling.
//  Revision    : 1.0  initial release
// ============================================================================
module text_console
    import textmode_pkg::*;
#(
    parameter int         COLS           = TM_COLS,
    parameter int         ROWS           = TM_ROWS,
    parameter logic [7:0] FILL_CHR       = 8'h20,
    parameter bit         CLEAR_ON_RESET = 1'b1
) (
    input  wire logic        clk_sys,
    input  wire logic        rst_n,
    text_console_if.slave    bus,
    output      logic [6:0]  cur_x,
    output      logic [5:0]  cur_y,
    output      logic        busy
);

    localparam int XW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int YW = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [XW-1:0] CNT_X_LAST = XW'(COLS - 1);
    localparam logic [YW-1:0] CNT_Y_LAST = YW'(ROWS - 1);
    localparam logic [6:0]    CUR_X_LAST = 7'(COLS - 1);
    localparam logic [5:0]    CUR_Y_LAST = 6'(ROWS - 1);

    localparam console_state_t RESET_STATE = CLEAR_ON_RESET ? CLR_SCREEN : IDLE;

    console_state_t state;
    logic [XW-1:0]  cnt_x;
    logic [YW-1:0]  cnt_y;
    logic [5:0]     next_row;
    logic           printable;

    // Row entered by a line advance; wraps to the top instead of scrolling
    always_comb begin
        next_row  = (cur_y == CUR_Y_LAST) ? 6'd0 : cur_y + 6'd1;
        printable = (bus.in_chr >= PRINT_LO) && (bus.in_chr <= PRINT_HI);
    end

    assign bus.in_ready = (state == IDLE);
    assign busy         = (state != IDLE);

    // Cursor, clear sequencer and registered write bus
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state        <= RESET_STATE;
            cnt_x        <= '0;
            cnt_y        <= '0;
            cur_x        <= 7'd0;
            cur_y        <= 6'd0;
            bus.char_str <= 1'b0;
            bus.char_x   <= 7'd0;
            bus.char_y   <= 6'd0;
            bus.char_chr <= 9'd0;
        end else begin
            bus.char_str <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (printable) begin
                            bus.char_str <= 1'b1;
                            bus.char_x   <= cur_x;
                            bus.char_y   <= cur_y;
                            bus.char_chr <= {1'b0, bus.in_chr};
                            if (cur_x < CUR_X_LAST) begin
                                cur_x <= cur_x + 7'd1;
                            end else begin
                                // Wrapped past the last column: advance and clear
                                cur_x <= 7'd0;
                                cur_y <= next_row;
                                cnt_x <= '0;
                                state <= CLR_LINE;
                            end
                        end else begin
                            case (bus.in_chr)
                                CC_LF: begin
                                    cur_x <= 7'd0;
                                    cur_y <= next_row;
                                    cnt_x <= '0;
                                    state <= CLR_LINE;
                                end
                                CC_CR: begin
                                    cur_x <= 7'd0;
                                end
                                CC_BS: begin
                                    if (cur_x != 7'd0) begin
                                        cur_x        <= cur_x - 7'd1;
                                        bus.char_str <= 1'b1;
                                        bus.char_x   <= cur_x - 7'd1;
                                        bus.char_y   <= cur_y;
                                        bus.char_chr <= {1'b0, FILL_CHR};
                                    end
                                end
                                CC_FF: begin
                                    cur_x <= 7'd0;
                                    cur_y <= 6'd0;
                                    cnt_x <= '0;
                                    cnt_y <= '0;
                                    state <= CLR_SCREEN;
                                end
                                default: begin
                                    // Unsupported code: consumed silently
                                end
                            endcase
                        end
                    end
                end

                CLR_LINE: begin
                    bus.char_str <= 1'b1;
                    bus.char_x   <= 7'(cnt_x);
                    bus.char_y   <= cur_y;
                    bus.char_chr <= {1'b0, FILL_CHR};
                    if (cnt_x == CNT_X_LAST) begin
                        cnt_x <= '0;
                        state <= IDLE;
                    end else begin
                        cnt_x <= cnt_x + 1'b1;
                    end
                end

                CLR_SCREEN: begin
                    bus.char_str <= 1'b1;
                    bus.char_x   <= 7'(cnt_x);
                    bus.char_y   <= 6'(cnt_y);
                    bus.char_chr <= {1'b0, FILL_CHR};
                    if (cnt_x == CNT_X_LAST) begin
                        cnt_x <= '0;
                        if (cnt_y == CNT_Y_LAST) begin
                            cnt_y <= '0;
                            state <= IDLE;
                        end else begin
                            cnt_y <= cnt_y + 1'b1;
                        end
                    end else begin
                        cnt_x <= cnt_x + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_text_console.sv
`default_nettype none
// ============================================================================
//  Module      : tb_text_console
//  Description : Self-checking bench for text_console: table of single-byte
//                vectors plus directed wrap, line-advance, backspace and
//                reset-abort sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_text_console;
    import textmode_pkg::*;

    localparam int COLS  = 80;
    localparam int ROWS  = 30;
    localparam int LIMIT = 3000;

    logic       clk_sys = 1'b0;
    logic       rst_n;
    logic [6:0] cur_x;
    logic [5:0] cur_y;
    logic       busy;

    int total = 0;
    int bad   = 0;

    text_console_if bus ();

    text_console #(
        .COLS           (COLS),
        .ROWS           (ROWS),
        .FILL_CHR       (8'h20),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .bus     (bus),
        .cur_x   (cur_x),
        .cur_y   (cur_y),
        .busy    (busy)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [7:0] chr;
        logic       wr;
        logic [6:0] x;
        logic [5:0] y;
        logic [7:0] code;
        logic [6:0] cx;
        logic [5:0] cy;
    } vec_t;

    vec_t tab [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    function automatic logic [22:0] wr_act();
        return bus.char_str ? {1'b1, bus.char_x, bus.char_y, bus.char_chr} : 23'd0;
    endfunction

    function automatic logic [22:0] wr_exp(input logic wr, input logic [6:0] x,
                                           input logic [5:0] y, input logic [7:0] c);
        return wr ? {1'b1, x, y, 1'b0, c} : 23'd0;
    endfunction

    // Present a byte, wait (bounded) for acceptance, return one cycle later
    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        bus.in_chr   = b;
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && n < LIMIT) begin
            tick();
            n++;
        end
        if (n >= LIMIT) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: actual=%0d required<%0d", n, LIMIT);
        end
        tick();
        bus.in_valid = 1'b0;
    endtask

    // Expect n consecutive fill writes; row<0 means a row-major screen clear
    task automatic expect_clear(input string name, input int n, input int row);
        int errs;
        int ex_x;
        int ex_y;
        logic ok;
        errs = 0;
        for (int k = 0; k < n; k++) begin
            tick();
            ex_x = (row < 0) ? (k % COLS) : k;
            ex_y = (row < 0) ? (k / COLS) : row;
            ok = (bus.char_str === 1'b1) && (bus.char_x === 7'(ex_x)) &&
                 (bus.char_y === 6'(ex_y)) && (bus.char_chr === 9'h020) &&
                 ((k == n - 1) || (busy === 1'b1 && bus.in_ready === 1'b0));
            if (!ok) errs++;
        end
        check({name, "_cells"}, errs, 0);
        tick();
        check({name, "_done"}, {bus.char_str, busy, bus.in_ready}, 3'b001);
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.in_chr   = 8'h00;
        bus.in_valid = 1'b0;

        tab[0]  = '{8'h41, 1'b1, 7'd0, 6'd0, 8'h41, 7'd1, 6'd0};
        tab[1]  = '{8'h42, 1'b1, 7'd1, 6'd0, 8'h42, 7'd2, 6'd0};
        tab[2]  = '{8'h07, 1'b0, 7'd0, 6'd0, 8'h00, 7'd2, 6'd0};
        tab[3]  = '{8'hC1, 1'b0, 7'd0, 6'd0, 8'h00, 7'd2, 6'd0};
        tab[4]  = '{8'h7F, 1'b1, 7'd2, 6'd0, 8'h7F, 7'd3, 6'd0};
        tab[5]  = '{8'h08, 1'b1, 7'd2, 6'd0, 8'h20, 7'd2, 6'd0};
        tab[6]  = '{8'h0D, 1'b0, 7'd0, 6'd0, 8'h00, 7'd0, 6'd0};
        tab[7]  = '{8'h08, 1'b0, 7'd0, 6'd0, 8'h00, 7'd0, 6'd0};
        tab[8]  = '{8'h1F, 1'b0, 7'd0, 6'd0, 8'h00, 7'd0, 6'd0};
        tab[9]  = '{8'h20, 1'b1, 7'd0, 6'd0, 8'h20, 7'd1, 6'd0};
        tab[10] = '{8'h7E, 1'b1, 7'd1, 6'd0, 8'h7E, 7'd2, 6'd0};
        tab[11] = '{8'h80, 1'b0, 7'd0, 6'd0, 8'h00, 7'd2, 6'd0};

        // Reset state
        repeat (3) tick();
        check("rst_str",   bus.char_str, 1'b0);
        check("rst_xy",    {bus.char_x, bus.char_y}, 13'd0);
        check("rst_chr",   bus.char_chr, 9'd0);
        check("rst_cur",   {cur_x, cur_y}, 13'd0);
        check("rst_rdy_busy", {bus.in_ready, busy}, 2'b01);

        // Power-on full-screen clear
        rst_n = 1'b1;
        expect_clear("por", ROWS * COLS, -1);
        check("por_cur", {cur_x, cur_y}, 13'd0);

        // Single-byte vector table
        for (int i = 0; i < 12; i++) begin
            send(tab[i].chr);
            check($sformatf("vec%0d_wr", i), wr_act(),
                  wr_exp(tab[i].wr, tab[i].x, tab[i].y, tab[i].code));
            check($sformatf("vec%0d_cur", i), {cur_x, cur_y}, {tab[i].cx, tab[i].cy});
        end

        // Printable byte at last column: write, wrap, clear the new row
        send(CC_CR);
        repeat (5) send(CC_LF);
        repeat (79) send(8'h78);
        check("pre_z_cur", {cur_x, cur_y}, {7'd79, 6'd5});
        send(8'h5A);
        check("z_wr", wr_act(), wr_exp(1'b1, 7'd79, 6'd5, 8'h5A));
        check("z_cur", {cur_x, cur_y}, {7'd0, 6'd6});
        check("z_ready", bus.in_ready, 1'b0);
        expect_clear("row6", COLS, 6);

        // LF on the bottom row wraps to the top and clears row 0
        repeat (23) send(CC_LF);
        repeat (10) send(8'h79);
        check("pre_lf_cur", {cur_x, cur_y}, {7'd10, 6'd29});
        send(CC_LF);
        check("lf_nowr", bus.char_str, 1'b0);
        check("lf_cur", {cur_x, cur_y}, 13'd0);
        expect_clear("row0", COLS, 0);

        // Backspace mid-row and at column 0
        repeat (2) send(CC_LF);
        repeat (3) send(8'h61);
        check("pre_bs_cur", {cur_x, cur_y}, {7'd3, 6'd2});
        send(CC_BS);
        check("bs_wr", wr_act(), wr_exp(1'b1, 7'd2, 6'd2, 8'h20));
        check("bs_cur", {cur_x, cur_y}, {7'd2, 6'd2});
        send(CC_CR);
        send(CC_BS);
        check("bs0_nowr", bus.char_str, 1'b0);
        check("bs0_cur", {cur_x, cur_y}, {7'd0, 6'd2});

        // Form feed clear aborted by reset after 500 writes
        send(CC_FF);
        check("ff_state", {cur_x, cur_y, busy, bus.in_ready}, {13'd0, 2'b10});
        repeat (500) tick();
        check("ff_mid_wr", wr_act(), wr_exp(1'b1, 7'd19, 6'd6, 8'h20));
        rst_n = 1'b0;
        #1;
        check("abort_str", bus.char_str, 1'b0);
        check("abort_xy",  {bus.char_x, bus.char_y, bus.char_chr}, 22'd0);
        check("abort_rdy_busy", {bus.in_ready, busy}, 2'b01);
        tick();
        rst_n = 1'b1;
        expect_clear("reclear", ROWS * COLS, -1);
        check("reclear_cur", {cur_x, cur_y}, 13'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
